fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the RV32I pipeline.
- Tracks in-flight destination tags (GPR and CSR) for every stage from EX to WB in an internal tag pipeline.
- Compares ID-stage sources against the tracked tags and produces registered forward selects that are valid when the instruction reaches EX.
- Raises a load-use / long-latency stall when the youngest matching producer's data will not yet be available.

Parameters:
- NUM_STAGES, 3: tracked stages EX..WB; entry 0=EX, 1=MEM, 2=WB, ...
- REG_AW, 5: GPR address width.
- CSR_AW, 12: CSR address width.
- ALU_READY, 1: stage index at which ALU/CSR results become forwardable.
- LOAD_READY, 2: stage index at which load data becomes forwardable; must be in ALU_READY..NUM_STAGES-1.
- SEL_W, $clog2(NUM_STAGES): derived width of a forward select.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs1  in  REG_AW  source 1 address
- id_rs2  in  REG_AW  source 2 address
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  REG_AW  destination address
- id_reg_write  in  1  instruction writes rd
- id_is_load  in  1  rd produced by load
- id_csr_addr  in  CSR_AW  CSR address
- id_csr_read  in  1  instruction reads the CSR
- id_csr_write  in  1  instruction writes the CSR
- pipe_hold  in  1  external freeze (e.g. memory wait)
- flush  in  1  kill ID and EX (branch taken)
- hazard_stall  out  1  hold PC/IF/ID, inject bubble into EX
- ex_fwd1_sel  out  SEL_W  EX operand 1 source: 0=regfile, k=stage k
- ex_fwd2_sel  out  SEL_W  EX operand 2 source
- ex_csr_fwd_sel  out  SEL_W  EX CSR read source

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Tag entry fields: valid, rd, reg_write, is_load, csr_addr, csr_write.
- Clock, reset and advance:
  - On reset, all entries are invalid and all outputs are 0, including hazard_stall.
  - pipe_hold=1: entries and registered selects hold; hazard_stall is still evaluated combinationally.
  - Otherwise, entry i <= entry i-1 for i>=1.
  - Entry 0 <= ID fields if id_valid && !hazard_stall && !flush; otherwise a bubble.
  - Priority: reset > pipe_hold > flush > hazard_stall > issue.
- Match (combinational):
  - GPR: entry j matches source s if valid, reg_write, rd==s, s!=0, and the source is used.
  - CSR: entry j matches if valid, csr_write, csr_addr==id_csr_addr, and id_csr_read.
  - The youngest match wins (lowest j). x0 never matches.
- Ready rule: the producer in entry j sits at stage j+1 when the consumer is in EX. It is ready iff j+1 >= (is_load ? LOAD_READY : ALU_READY).
- hazard_stall = id_valid && !flush && (the youngest match on any used source, or on the CSR, is not ready).
- Forward selects are registered and updated only when the pipe advances.
  - Next value = j+1 for a youngest match with j+1 <= NUM_STAGES-1; otherwise 0.
  - The entry at the last stage (WB) is covered by regfile write-through, so it is never selected.
  - When a bubble enters EX (stall, flush or !id_valid), the selects become 0.
- Latency: stall is 0 cycles (combinational); selects are 1 cycle (valid with the instruction in EX).
- Reset mid-operation: all in-flight tags are discarded, with no residual stall.
- With the defaults, a load followed immediately by a dependent instruction gives exactly 1 stall cycle, then ex_fwdN_sel=2.

Decomposition:
- Shared package/defines: stage index constants (STAGE_EX=0, STAGE_MEM=1, STAGE_WB=2), forward-select encodings (FWD_RF=0) and the tag-entry field layout.
- One natural sub-module, fwd_tag_stage: a single tag register with hold, bubble and flush controls, instantiated NUM_STAGES times via generate.
- Match, priority and select logic stays in the top level.

Test Plan:
- ALU back-to-back: addi x5 then add x6,x5,x5 -> no stall; next cycle ex_fwd1_sel=ex_fwd2_sel=1.
- Load-use: lw x7 then add x8,x7,x0 -> hazard_stall=1 for exactly 1 cycle; then ex_fwd1_sel=2, ex_fwd2_sel=0.
- Youngest wins: x3 written by instruction A then B; C reads x3 one instruction after B -> ex_fwd1_sel=1 (B), not 2.
- x0 and unused sources:
  - addi x0 then add x1,x0,x0 -> selects 0, no stall.
  - rs2_used=0 with a matching rd -> ex_fwd2_sel=0.
- CSR: csrw 0x300 then csrr 0x300 -> ex_csr_fwd_sel=1. With a different address 0x305 -> 0.
- Control interaction:
  - flush during a load-use stall -> stall drops and EX gets a bubble.
  - pipe_hold for 3 cycles -> selects and tags are frozen.
  - reset asserted mid-stream -> next cycle all outputs are 0.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared stage indices, forward-select encodings and tag-entry flag layout
package fwd_hazard_unit_pkg;
  localparam int STAGE_EX = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB = 2;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic reg_write;
    logic is_load;
    logic csr_write;
  } tag_flags_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage operand/destination info in, stall and EX forward selects out
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12,
  parameter int SEL_W = 2
);
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
  logic id_csr_read, id_csr_write, pipe_hold, flush;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [CSR_AW-1:0] id_csr_addr;
  logic hazard_stall;
  logic [SEL_W-1:0] ex_fwd1_sel, ex_fwd2_sel, ex_csr_fwd_sel;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write, id_is_load,
    output id_csr_addr, id_csr_read, id_csr_write, pipe_hold, flush,
    input hazard_stall, ex_fwd1_sel, ex_fwd2_sel, ex_csr_fwd_sel
  );
  modport slave (
    input id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write, id_is_load,
    input id_csr_addr, id_csr_read, id_csr_write, pipe_hold, flush,
    output hazard_stall, ex_fwd1_sel, ex_fwd2_sel, ex_csr_fwd_sel
  );
endinterface

// File: rtl/fwd_tag_stage.sv
// fwd_tag_stage: one in-flight destination tag register with hold, bubble and flush controls
module fwd_tag_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic valid_q, valid_d;
  logic [W-1:0] data_q;
  assign valid_d = valid_i && !bubble_i && !flush_i;
  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else if (!hold_i) begin
      valid_q <= valid_d;
      data_q <= data_i;
    end
  assign valid_o = valid_q;
  assign data_o = data_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight GPR/CSR destination tags, raises load-use stalls and registers EX forward selects
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12,
  parameter int ALU_READY = 1,
  parameter int LOAD_READY = 2,
  parameter int SEL_W = $clog2(NUM_STAGES)
) (
  input logic clk,
  input logic reset,
  fwd_hazard_unit_if.slave io
);
  typedef struct packed {
    tag_flags_t f;
    logic [REG_AW-1:0] rd;
    logic [CSR_AW-1:0] csr_addr;
  } tag_t;
  tag_t tag_q [NUM_STAGES];
  tag_t tag_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_q, vld_d;
  logic [NUM_STAGES-1:0] m [3];
  int stg [3];
  logic [2:0] wait_s;
  logic [SEL_W-1:0] sel_d [3];
  logic [SEL_W-1:0] sel_q [3];
  logic stall, issue;
  always_comb begin
    vld_d[0] = io.id_valid;
    tag_d[0].f.reg_write = io.id_reg_write;
    tag_d[0].f.is_load = io.id_is_load;
    tag_d[0].f.csr_write = io.id_csr_write;
    tag_d[0].rd = io.id_rd;
    tag_d[0].csr_addr = io.id_csr_addr;
    for (int j = 1; j < NUM_STAGES; j++) begin
      vld_d[j] = vld_q[j-1];
      tag_d[j] = tag_q[j-1];
    end
  end
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    fwd_tag_stage #(.W($bits(tag_t))) u_stage (
      .clk      (clk),
      .rst      (reset),
      .hold_i   (io.pipe_hold),
      .bubble_i (i == STAGE_EX ? stall : 1'b0),
      .flush_i  (i == STAGE_EX ? io.flush : 1'b0),
      .valid_i  (vld_d[i]),
      .data_i   (tag_d[i]),
      .valid_o  (vld_q[i]),
      .data_o   (tag_q[i])
    );
  end
  // Scan oldest to youngest so the youngest matching producer overwrites the result.
  always_comb begin
    for (int j = 0; j < NUM_STAGES; j++) begin
      m[0][j] = vld_q[j] && tag_q[j].f.reg_write && tag_q[j].rd == io.id_rs1 && io.id_rs1 != '0 && io.id_rs1_used;
      m[1][j] = vld_q[j] && tag_q[j].f.reg_write && tag_q[j].rd == io.id_rs2 && io.id_rs2 != '0 && io.id_rs2_used;
      m[2][j] = vld_q[j] && tag_q[j].f.csr_write && tag_q[j].csr_addr == io.id_csr_addr && io.id_csr_read;
    end
    for (int s = 0; s < 3; s++) begin
      stg[s] = 0;
      wait_s[s] = 1'b0;
      for (int j = NUM_STAGES - 1; j >= 0; j--)
        if (m[s][j]) begin
          stg[s] = j + 1;
          wait_s[s] = j + 1 < (tag_q[j].f.is_load ? LOAD_READY : ALU_READY);
        end
    end
  end
  assign stall = !reset && io.id_valid && !io.flush && |wait_s;
  assign issue = io.id_valid && !stall && !io.flush;
  // The producer at the last tracked stage reaches EX via regfile write-through.
  always_comb
    for (int s = 0; s < 3; s++)
      sel_d[s] = (issue && stg[s] != 0 && stg[s] < NUM_STAGES) ? SEL_W'(stg[s]) : SEL_W'(FWD_RF);
  always_ff @(posedge clk)
    if (reset) sel_q <= '{default: '0};
    else if (!io.pipe_hold) sel_q <= sel_d;
  assign io.hazard_stall = stall;
  assign io.ex_fwd1_sel = sel_q[0];
  assign io.ex_fwd2_sel = sel_q[1];
  assign io.ex_csr_fwd_sel = sel_q[2];
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed pipeline sequences; stall checked in-cycle, forward selects via a one-cycle scoreboard queue
module tb_fwd_hazard_unit;
  logic clk, reset;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int s1;
    int s2;
    int sc;
  } exp_t;
  exp_t q[$];
  fwd_hazard_unit_if #(.REG_AW(5), .CSR_AW(12), .SEL_W(2)) bus ();
  fwd_hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic drive(input int v, input int rd, input int w, input int ld, input int rs1, input int u1,
                       input int rs2, input int u2, input int a, input int cr, input int cw);
    bus.id_valid = (v != 0);
    bus.id_rd = 5'(rd);
    bus.id_reg_write = (w != 0);
    bus.id_is_load = (ld != 0);
    bus.id_rs1 = 5'(rs1);
    bus.id_rs1_used = (u1 != 0);
    bus.id_rs2 = 5'(rs2);
    bus.id_rs2_used = (u2 != 0);
    bus.id_csr_addr = 12'(a);
    bus.id_csr_read = (cr != 0);
    bus.id_csr_write = (cw != 0);
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input int rd, input int rs1, input int rs2, input int u1, input int u2);
    drive(1, rd, 1, 0, rs1, u1, rs2, u2, 0, 0, 0);
  endtask
  task automatic lw(input int rd);
    drive(1, rd, 1, 1, 0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic csr(input int rd, input int a, input int cr, input int cw);
    drive(1, rd, (rd != 0) ? 1 : 0, 0, 0, 0, 0, 0, a, cr, cw);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Checks this cycle's stall, pops the selects promised last cycle, pushes next cycle's.
  task automatic cyc(input string tag, input int es, input int e1, input int e2, input int ec);
    exp_t x;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(bus.hazard_stall), es);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.queue: observed=empty expected=entry", tag);
    end else begin
      x = q.pop_front();
      chk({tag, ".fwd1"}, 32'(bus.ex_fwd1_sel), x.s1);
      chk({tag, ".fwd2"}, 32'(bus.ex_fwd2_sel), x.s2);
      chk({tag, ".csr"}, 32'(bus.ex_csr_fwd_sel), x.sc);
    end
    x.s1 = e1;
    x.s2 = e2;
    x.sc = ec;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t z;
    reset = 1'b1;
    bus.pipe_hold = 1'b0;
    bus.flush = 1'b0;
    nop();
    z.s1 = 0;
    z.s2 = 0;
    z.sc = 0;
    q.push_back(z);
    @(posedge clk);
    #1;
    cyc("rst0", 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, 0);
    reset = 1'b0;
    alu(5, 0, 0, 1, 0);   cyc("addi_x5", 0, 0, 0, 0);
    alu(6, 5, 5, 1, 1);   cyc("add_x6", 0, 1, 1, 0);
    nop();                cyc("alu_fwd", 0, 0, 0, 0);
    lw(7);                cyc("lw_x7", 0, 0, 0, 0);
    alu(8, 7, 0, 1, 1);   cyc("lu_stall", 1, 0, 0, 0);
                          cyc("lu_release", 0, 2, 0, 0);
    nop();                cyc("lu_fwd", 0, 0, 0, 0);
    alu(3, 0, 0, 1, 0);   cyc("wr_a", 0, 0, 0, 0);
    alu(3, 0, 0, 1, 0);   cyc("wr_b", 0, 0, 0, 0);
    alu(9, 3, 0, 1, 0);   cyc("rd_c", 0, 1, 0, 0);
    nop();                cyc("youngest", 0, 0, 0, 0);
    alu(0, 0, 0, 1, 0);   cyc("addi_x0", 0, 0, 0, 0);
    alu(1, 0, 0, 1, 1);   cyc("rd_x0", 0, 0, 0, 0);
    alu(10, 0, 0, 1, 0);  cyc("addi_x10", 0, 0, 0, 0);
    alu(11, 10, 10, 1, 0); cyc("rs2_unused", 0, 1, 0, 0);
    csr(0, 'h300, 0, 1);  cyc("csrw_300", 0, 0, 0, 0);
    csr(12, 'h300, 1, 0); cyc("csrr_300", 0, 0, 0, 1);
    csr(13, 'h305, 1, 0); cyc("csrr_305", 0, 0, 0, 0);
    lw(23);               cyc("lw_x23", 0, 0, 0, 0);
    alu(14, 23, 0, 1, 0); bus.flush = 1'b1; cyc("flush_stall", 0, 0, 0, 0);
    bus.flush = 1'b0; alu(15, 14, 0, 1, 0); cyc("post_flush", 0, 0, 0, 0);
    nop();                cyc("flush_bubble", 0, 0, 0, 0);
    alu(16, 0, 0, 1, 0);  cyc("addi_x16", 0, 0, 0, 0);
    alu(17, 16, 0, 1, 0); cyc("add_x17", 0, 1, 0, 0);
    bus.pipe_hold = 1'b1; alu(18, 16, 0, 1, 0);
    cyc("hold0", 0, 1, 0, 0);
    cyc("hold1", 0, 1, 0, 0);
    cyc("hold2", 0, 1, 0, 0);
    bus.pipe_hold = 1'b0; cyc("hold_rel", 0, 2, 0, 0);
    lw(19);               cyc("lw_x19", 0, 0, 0, 0);
    bus.pipe_hold = 1'b1; alu(22, 19, 0, 1, 0); cyc("hold_stall", 1, 0, 0, 0);
    bus.pipe_hold = 1'b0; cyc("stall_after_hold", 1, 0, 0, 0);
                          cyc("lu2_release", 0, 2, 0, 0);
    nop();                cyc("lu2_fwd", 0, 0, 0, 0);
    lw(20);               cyc("lw_x20", 0, 0, 0, 0);
    alu(21, 20, 0, 1, 0); reset = 1'b1; cyc("reset_mid", 0, 0, 0, 0);
    reset = 1'b0;         cyc("post_reset", 0, 0, 0, 0);
    nop();                cyc("post_reset_sel", 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
